// File: rtl/frac_clock_gen.sv
// frac_clock_gen: multi-channel phase-accumulator clock generator with glitch-free retune and sync
module frac_clock_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W = 24,
  parameter logic [CHANNELS*ACC_W-1:0] DEF_INC = {24'hFBA882, 24'h8F5C29},
  parameter logic [CHANNELS-1:0] DEF_EN = 2'b11
) (
  input  logic                clk50m,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_sel,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce_out,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] pending
);
  logic [CHANNELS-1:0] r_en;
  always_ff @(posedge clk50m)
    if (reset) r_en <= DEF_EN;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ACC_W-1:0] r_acc, r_inc, r_shadow, w_sum;
    logic r_pend, r_ce, r_clk, w_carry, w_run, w_wr, w_apply;
    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_run = ~sync & ch_en[g] & r_en[g] & (r_inc != '0);
    assign w_wr = cfg_we & (cfg_sel == 3'(g));
    // retune only at a period boundary, or whenever the channel is idle or being re-phased
    assign w_apply = r_pend & (~w_run | w_carry);
    always_ff @(posedge clk50m) begin
      if (reset) begin
        r_acc <= '0;
        r_inc <= DEF_INC[g*ACC_W +: ACC_W];
        r_shadow <= DEF_INC[g*ACC_W +: ACC_W];
        r_pend <= 1'b0;
        r_ce <= 1'b0;
        r_clk <= 1'b0;
      end else begin
        if (sync) begin
          r_acc <= '0;
          r_clk <= 1'b0;
          r_ce <= 1'b0;
        end else if (w_run) begin
          r_acc <= w_sum;
          r_ce <= w_carry;
          if (w_carry) r_clk <= ~r_clk;
        end else r_ce <= 1'b0;
        if (w_apply) r_inc <= r_shadow;
        if (w_wr) begin
          r_shadow <= cfg_inc;
          r_pend <= 1'b1;
        end else if (w_apply) r_pend <= 1'b0;
      end
    end
    assign ce_out[g] = r_ce;
    assign clk_out[g] = r_clk;
    assign pending[g] = r_pend;
  end
endmodule

// File: tb/tb_frac_clock_gen.sv
// tb_frac_clock_gen: directed checks of rate, fraction, retune, boundaries, sync and reset
module tb_frac_clock_gen;
  logic clk50m = 1'b0;
  logic reset = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [23:0] cfg_inc = '0;
  logic [1:0] ch_en = 2'b11;
  logic sync = 1'b0;
  logic [1:0] ce_out, clk_out, pending;
  int vec = 0;
  int miss = 0;

  frac_clock_gen dut (
    .clk50m(clk50m), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc),
    .ch_en(ch_en), .sync(sync), .ce_out(ce_out), .clk_out(clk_out), .pending(pending)
  );

  always #10 clk50m = ~clk50m;

  task automatic tick;
    @(posedge clk50m);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [23:0] val);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_inc = val;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_sync;
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic test_reset;
    ch_en = 2'b11;
    reset = 1'b1;
    tick();
    tick();
    vec++;
    if ({ce_out, clk_out, pending} !== 6'b0) begin
      miss++;
      $display("FAIL reset_state: got ce=%b clk=%b pend=%b want all 0", ce_out, clk_out, pending);
    end
    reset = 1'b0;
    wr(3'd5, 24'h123456);
    vec++;
    if (pending !== 2'b00) begin
      miss++;
      $display("FAIL bad_sel: got pending=%b want 00", pending);
    end
  endtask

  task automatic test_basic;
    do_reset();
    wr(3'd0, 24'h400000);
    pulse_sync();
    vec++;
    if (pending[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      miss++;
      $display("FAIL basic_sync: got pend=%b clk=%b want 0 0", pending[0], clk_out[0]);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      vec++;
      if (ce_out[0] !== (k % 4 == 0) || clk_out[0] !== ((k / 4) % 2 == 1)) begin
        miss++;
        $display("FAIL basic_rate cyc %0d: got ce=%b clk=%b want ce=%b clk=%b",
                 k, ce_out[0], clk_out[0], k % 4 == 0, (k / 4) % 2 == 1);
      end
    end
  endtask

  task automatic test_fractional;
    int cnt, last, bad;
    cnt = 0;
    last = 0;
    bad = 0;
    do_reset();
    wr(3'd0, 24'h555555);
    pulse_sync();
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (ce_out[0] === 1'b1) begin
        if (cnt > 0 && (k - last < 3 || k - last > 4)) bad++;
        cnt++;
        last = k;
      end
    end
    vec++;
    if (cnt !== 999) begin
      miss++;
      $display("FAIL frac_count: got %0d want 999", cnt);
    end
    vec++;
    if (bad !== 0) begin
      miss++;
      $display("FAIL frac_spacing: got %0d bad gaps want 0", bad);
    end
  endtask

  task automatic test_retune;
    logic [2:0] exp_pce [7:12];
    do_reset();
    wr(3'd0, 24'h400000);
    pulse_sync();
    for (int k = 1; k <= 5; k++) tick();
    wr(3'd0, 24'h800000);
    exp_pce[7] = 3'b010;
    exp_pce[8] = 3'b100;
    exp_pce[9] = 3'b000;
    exp_pce[10] = 3'b100;
    exp_pce[11] = 3'b000;
    exp_pce[12] = 3'b100;
    vec++;
    if (pending[0] !== 1'b1 || ce_out[0] !== 1'b0) begin
      miss++;
      $display("FAIL retune_wr: got pend=%b ce=%b want 1 0", pending[0], ce_out[0]);
    end
    for (int k = 7; k <= 12; k++) begin
      tick();
      vec++;
      if ({ce_out[0], pending[0], 1'b0} !== exp_pce[k]) begin
        miss++;
        $display("FAIL retune cyc %0d: got ce=%b pend=%b want ce=%b pend=%b",
                 k, ce_out[0], pending[0], exp_pce[k][2], exp_pce[k][1]);
      end
    end
  endtask

  task automatic test_boundary;
    int hits;
    hits = 0;
    do_reset();
    wr(3'd0, 24'h000000);
    pulse_sync();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce_out[0] !== 1'b0 || clk_out[0] !== 1'b0) hits++;
    end
    vec++;
    if (hits !== 0) begin
      miss++;
      $display("FAIL inc_zero: got %0d active cycles want 0", hits);
    end
    wr(3'd0, 24'hFFFFFF);
    pulse_sync();
    tick();
    vec++;
    if (ce_out[0] !== 1'b0) begin
      miss++;
      $display("FAIL max_first: got ce=%b want 0", ce_out[0]);
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      vec++;
      if (ce_out[0] !== 1'b1 || clk_out[0] !== (k % 2 == 0)) begin
        miss++;
        $display("FAIL max_run cyc %0d: got ce=%b clk=%b want ce=1 clk=%b",
                 k, ce_out[0], clk_out[0], k % 2 == 0);
      end
    end
    ch_en = 2'b10;
    for (int k = 7; k <= 12; k++) begin
      tick();
      vec++;
      if (ce_out[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
        miss++;
        $display("FAIL ch_en_off cyc %0d: got ce=%b clk=%b want 0 1", k, ce_out[0], clk_out[0]);
      end
    end
    ch_en = 2'b11;
  endtask

  task automatic test_sync;
    do_reset();
    wr(3'd0, 24'h200000);
    wr(3'd1, 24'h300000);
    for (int k = 0; k < 7; k++) tick();
    pulse_sync();
    vec++;
    if (clk_out !== 2'b00 || ce_out !== 2'b00 || pending !== 2'b00) begin
      miss++;
      $display("FAIL sync_state: got clk=%b ce=%b pend=%b want 00 00 00", clk_out, ce_out, pending);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++;
      if (ce_out !== {k == 6, k == 8}) begin
        miss++;
        $display("FAIL sync_ce cyc %0d: got %b want %b", k, ce_out, {k == 6, k == 8});
      end
    end
  endtask

  task automatic test_reset_midop;
    int c0, c1;
    c0 = 0;
    c1 = 0;
    do_reset();
    wr(3'd0, 24'h400000);
    pulse_sync();
    for (int k = 1; k <= 4; k++) tick();
    wr(3'd0, 24'h800000);
    vec++;
    if (clk_out[0] !== 1'b1 || pending[0] !== 1'b1) begin
      miss++;
      $display("FAIL midop_pre: got clk=%b pend=%b want 1 1", clk_out[0], pending[0]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec++;
    if ({ce_out, clk_out, pending} !== 6'b0) begin
      miss++;
      $display("FAIL midop_reset: got ce=%b clk=%b pend=%b want all 0", ce_out, clk_out, pending);
    end
    for (int k = 1; k <= 50; k++) begin
      tick();
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
    end
    vec++;
    if (c0 !== 28) begin
      miss++;
      $display("FAIL default_ch0: got %0d ce in 50 cycles want 28", c0);
    end
    vec++;
    if (c1 !== 49) begin
      miss++;
      $display("FAIL default_ch1: got %0d ce in 50 cycles want 49", c1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fractional();
    test_retune();
    test_boundary();
    test_sync();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/frac_clock_gen.md
Name: frac_clock_gen

Overview:
- Multi-channel fractional clock generator running from the 50 MHz board clock.
- Each channel uses a phase accumulator (Bresenham-style) to produce a one-cycle clock-enable pulse and a toggled square-wave output at a runtime-programmable rate.
- Generalises the fixed 14 MHz / 24.576 MHz dividers: arbitrary ratios, N channels, glitch-free retuning and phase re-synchronisation.
- Feeds CPU/ULA timing (e.g. 128K 3.5469 MHz x4) and audio clocks.

Parameters:
- CHANNELS, 2, number of independent output channels (1..8).
- ACC_W, 24, accumulator and increment width in bits.
- DEF_INC, {24'hFBA882, 24'h8F5C29}, packed CHANNELS*ACC_W reset increments. Channel 0 is in the LSBs. Ch0 gives ce ≈28.000 MHz (14.000 MHz square); ch1 gives ce ≈49.152 MHz (24.576 MHz square).
- DEF_EN, 2'b11, reset value of the per-channel enable bits.

Ports:
- clk50m  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  one-cycle strobe; write cfg_inc to the shadow register of channel cfg_sel.
- cfg_sel  in  3  target channel; writes with cfg_sel >= CHANNELS are ignored.
- cfg_inc  in  ACC_W  new increment value.
- ch_en  in  CHANNELS  per-channel run enable, ANDed with the internal enable.
- sync  in  1  one-cycle strobe; phase-align all channels.
- ce_out  out  CHANNELS  one-cycle clock-enable pulses, registered.
- clk_out  out  CHANNELS  square outputs, registered; toggle on each ce.
- pending  out  CHANNELS  shadow increment waiting to be applied.

Behaviour:
- Per-channel state: acc[ACC_W], inc[ACC_W], shadow[ACC_W], pend, clk_out, ce_out.
- Reset (highest priority, any cycle, including mid-operation):
  - acc = 0, inc = shadow = DEF_INC slice, pend = 0.
  - ce_out = 0, clk_out = 0, pending = 0.
  - Internal enable = DEF_EN.
- Run condition: channel runs when reset=0, sync=0, ch_en[i]=1 and inc != 0.
- Each running cycle: {carry, acc_next} = {1'b0, acc} + {1'b0, inc}, computed in ACC_W+1 bits.
  - acc <= acc_next; wrap-around modulo 2^ACC_W is intended.
  - ce_out[i] <= carry.
  - If carry, clk_out[i] <= ~clk_out[i].
- Rates:
  - f_ce = f_clk * inc / 2^ACC_W.
  - f_clk_out = f_ce / 2.
  - ce_out never stays high for two cycles unless inc >= 2^(ACC_W-1).
- Non-running channel: acc, clk_out hold; ce_out <= 0.
- Config write (cfg_we=1, valid cfg_sel): shadow <= cfg_inc; pend <= 1. A second write before apply overwrites shadow; pend stays 1.
- Apply rule (glitch-free retune): inc <= shadow and pend <= 0 on the first cycle in which either:
  - the channel is running and carry=1 (the new inc is used from the next add), or
  - the channel is not running (disabled or inc=0), or
  - sync=1.
  - A write and an apply in the same cycle: the write wins; shadow takes the new value, pend=1, and the old shadow is applied.
- Sync (priority below reset), all channels:
  - acc <= 0, clk_out <= 0, ce_out <= 0.
  - Any pending shadow is applied.
  - Channels are phase-locked after sync when increments are equal.
- pending output = pend register, so it has zero latency relative to internal state.
- Latency: ce_out asserts the edge after the cycle whose add overflows. From acc=0 with inc=K, the first ce is at cycle ceil(2^ACC_W/K) after the first running edge.
- No combinational path from any input to any output.

Test Plan:
- Basic rate: ACC_W=24, inc=24'h400000 via cfg_we, then sync. Expect ce_out[0] every 4th cycle (first on cycle 4) and clk_out[0] period 8 cycles with 50% duty.
- Fractional: inc=24'h555555 for 3000 cycles. Expect ce count = 999 or 1000 and spacing only ever 3 or 4 cycles (never 2 or 5).
- Retune mid-phase: inc=24'h400000, write 24'h800000 at cycle 2 after a ce. Expect pending=1 until the next ce (cycle 4), then ce every 2 cycles with no short or merged pulse.
- Boundary: inc=0 gives no ce and frozen clk_out. inc=24'hFFFFFF from acc=0 gives no ce on cycle 1, then ce high continuously until acc wraps. ch_en=0 holds clk_out level and ce_out=0.
- Sync: two channels at 24'h200000 and 24'h300000, phases arbitrary; pulse sync. Expect both clk_out=0 next cycle and first ce at cycles 8 and 6 respectively.
- Reset mid-operation: assert reset while clk_out=1 with pending=1. Expect next cycle clk_out=0, ce_out=0, pending=0, inc back to DEF_INC, and the default 14 MHz square wave restarts (28 ce per ~50 cycles).
